// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified instruction/data RAM shared by fetch (IF) and load/store (DM).
// Data accesses win by default; a grant-streak limit guarantees fetch progress.
module mem_port_arbiter #(
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned MAX_STREAK  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        flush_i,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_wstrb_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        ram_en_o,
  output logic [3:0]  ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  localparam int unsigned    SW         = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [2:0]     LAT        = 3'(RAM_LATENCY);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          drop_q, drop_d;
  logic [SW-1:0] streak_q, streak_d;

  logic resp_s;
  logic free_s;
  logic dm_win_s;
  logic if_win_s;
  logic rd_gnt_s;
  logic if_rvalid_s;
  logic dm_rvalid_s;

  // The port frees up in the very cycle a read response completes, so reads can issue back to back.
  assign resp_s      = (state_q == ST_WAIT) && (cnt_q == 3'd1);
  assign free_s      = (state_q == ST_IDLE) || resp_s;
  assign dm_win_s    = free_s && dm_req_i && !(if_req_i && (streak_q == STREAK_MAX));
  assign if_win_s    = free_s && !dm_win_s && if_req_i;
  assign rd_gnt_s    = if_win_s || (dm_win_s && !dm_we_i);
  assign if_rvalid_s = resp_s && !owner_q && !drop_q && !flush_i;
  assign dm_rvalid_s = resp_s && owner_q;

  // Grant, RAM port and response outputs; everything is held at zero while reset is asserted.
  always_comb begin
    if_gnt_o    = 1'b0;
    dm_gnt_o    = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 4'b0000;
    ram_addr_o  = 32'h0000_0000;
    ram_wdata_o = 32'h0000_0000;
    if_rvalid_o = 1'b0;
    dm_rvalid_o = 1'b0;
    if_rdata_o  = 32'h0000_0000;
    dm_rdata_o  = 32'h0000_0000;
    if (rst_ni) begin
      if_gnt_o    = if_win_s;
      dm_gnt_o    = dm_win_s;
      ram_en_o    = if_win_s || dm_win_s;
      if_rvalid_o = if_rvalid_s;
      dm_rvalid_o = dm_rvalid_s;
      if (dm_win_s) begin
        ram_addr_o = dm_addr_i;
        if (dm_we_i) begin
          ram_we_o    = dm_wstrb_i;
          ram_wdata_o = dm_wdata_i;
        end else begin
          ram_we_o    = 4'b0000;
          ram_wdata_o = 32'h0000_0000;
        end
      end else if (if_win_s) begin
        ram_addr_o = if_addr_i;
      end else begin
        ram_addr_o = 32'h0000_0000;
      end
      if (if_rvalid_s) begin
        if_rdata_o = ram_rdata_i;
      end else begin
        if_rdata_o = 32'h0000_0000;
      end
      if (dm_rvalid_s) begin
        dm_rdata_o = ram_rdata_i;
      end else begin
        dm_rdata_o = 32'h0000_0000;
      end
    end else begin
      ram_en_o = 1'b0;
    end
  end

  // Next-state logic for the transaction tracker and the DM grant streak.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    drop_d   = drop_q;
    streak_d = streak_q;

    if (rd_gnt_s) begin
      state_d = ST_WAIT;
      cnt_d   = LAT;
      owner_d = dm_win_s;
      drop_d  = if_win_s && flush_i;
    end else if (resp_s) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      drop_d  = 1'b0;
    end else if (state_q == ST_WAIT) begin
      cnt_d  = cnt_q - 3'd1;
      drop_d = drop_q || (flush_i && !owner_q);
    end else begin
      state_d = ST_IDLE;
    end

    // The streak only counts DM wins that actually kept a waiting fetch out.
    if (!if_req_i || if_win_s) begin
      streak_d = '0;
    end else if (dm_win_s && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + SW'(1);
    end else begin
      streak_d = streak_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      owner_q  <= 1'b0;
      drop_q   <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      drop_q   <= drop_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a time-stamp based reference model
// and a small behavioural RAM that answers the DUT's own RAM port.
module tb_mem_port_arbiter;

  localparam int LAT = 3;
  localparam int MAX = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_ni;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        flush_i;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [3:0]  dm_wstrb_i;
  logic        dm_gnt_o;
  logic        dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;

  mem_port_arbiter #(
    .RAM_LATENCY (LAT),
    .MAX_STREAK  (MAX)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .flush_i     (flush_i),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_wstrb_i  (dm_wstrb_i),
    .dm_gnt_o    (dm_gnt_o),
    .dm_rvalid_o (dm_rvalid_o),
    .dm_rdata_o  (dm_rdata_o),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int if_wait = 0;

  // reference model: one outstanding read described by its due cycle
  bit          m_pend;
  bit          m_owner;
  bit          m_drop;
  int          m_due;
  int          m_streak;
  logic [31:0] m_data;
  logic [31:0] m_mem [16];

  // behavioural RAM driven by the DUT's port
  logic [31:0] e_mem [16];
  int          e_due [$];
  logic [31:0] e_dat [$];

  bit          g_if;
  bit          g_dm;
  logic        o_if_gnt;
  logic        o_dm_gnt;
  logic        o_ifv;
  logic        o_dmv;
  logic        o_ram_en;
  logic [3:0]  o_ram_we;
  logic [31:0] o_if_rdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  // One clock cycle: inputs were applied at the preceding negedge by the caller.
  task automatic step();
    bit          resp_now;
    bit          free;
    bit          e_ifv;
    bit          e_dmv;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_we;
    while (e_due.size() > 0 && e_due[0] < cyc) begin
      void'(e_due.pop_front());
      void'(e_dat.pop_front());
    end
    if (e_due.size() > 0 && e_due[0] == cyc) begin
      void'(e_due.pop_front());
      ram_rdata_i = e_dat.pop_front();
    end else begin
      ram_rdata_i = $urandom;
    end
    #2;
    o_if_gnt   = if_gnt_o;
    o_dm_gnt   = dm_gnt_o;
    o_ifv      = if_rvalid_o;
    o_dmv      = dm_rvalid_o;
    o_ram_en   = ram_en_o;
    o_ram_we   = ram_we_o;
    o_if_rdata = if_rdata_o;

    g_if = 1'b0; g_dm = 1'b0; e_ifv = 1'b0; e_dmv = 1'b0; resp_now = 1'b0;
    e_addr = 32'h0; e_wd = 32'h0; e_we = 4'h0;
    if (rst_ni) begin
      resp_now = m_pend && (m_due == cyc);
      free     = !m_pend || resp_now;
      g_dm     = free && dm_req_i && !(if_req_i && (m_streak == MAX));
      g_if     = free && !g_dm && if_req_i;
      e_ifv    = resp_now && !m_owner && !m_drop && !flush_i;
      e_dmv    = resp_now && m_owner;
      if (g_dm) begin
        e_addr = dm_addr_i;
        if (dm_we_i) begin
          e_we = dm_wstrb_i;
          e_wd = dm_wdata_i;
        end
      end else if (g_if) begin
        e_addr = if_addr_i;
      end
    end
    check_eq("if_gnt",    if_gnt_o,    g_if);
    check_eq("dm_gnt",    dm_gnt_o,    g_dm);
    check_eq("ram_en",    ram_en_o,    g_if || g_dm);
    check_eq("ram_we",    ram_we_o,    e_we);
    check_eq("ram_addr",  ram_addr_o,  e_addr);
    check_eq("ram_wdata", ram_wdata_o, e_wd);
    check_eq("if_rvalid", if_rvalid_o, e_ifv);
    check_eq("dm_rvalid", dm_rvalid_o, e_dmv);
    check_eq("if_rdata",  if_rdata_o,  e_ifv ? m_data : 32'h0);
    check_eq("dm_rdata",  dm_rdata_o,  e_dmv ? m_data : 32'h0);

    if (ram_en_o === 1'b1) begin
      if (ram_we_o == 4'h0) begin
        e_due.push_back(cyc + LAT);
        e_dat.push_back(e_mem[ram_addr_o[3:0]]);
      end else begin
        e_mem[ram_addr_o[3:0]] = merge(e_mem[ram_addr_o[3:0]], ram_wdata_o, ram_we_o);
      end
    end

    if (!rst_ni) begin
      if_wait = 0;
    end else if (o_if_gnt === 1'b1) begin
      check_eq("if_latency_bound", 32'(if_wait <= (MAX + 1) * LAT), 32'd1);
      if_wait = 0;
    end else if (if_req_i) begin
      if_wait++;
    end

    if (!rst_ni) begin
      m_pend = 1'b0; m_drop = 1'b0; m_streak = 0;
    end else begin
      if (resp_now) m_pend = 1'b0;
      else if (m_pend && flush_i && !m_owner) m_drop = 1'b1;
      if (g_if || (g_dm && !dm_we_i)) begin
        m_pend  = 1'b1;
        m_due   = cyc + LAT;
        m_owner = g_dm;
        m_drop  = g_if && flush_i;
        m_data  = g_dm ? m_mem[dm_addr_i[3:0]] : m_mem[if_addr_i[3:0]];
      end
      if (g_dm && dm_we_i) m_mem[dm_addr_i[3:0]] = merge(m_mem[dm_addr_i[3:0]], dm_wdata_i, dm_wstrb_i);
      if (!if_req_i || g_if) m_streak = 0;
      else if (g_dm && m_streak < MAX) m_streak++;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; if_req_i = 1'b0; if_addr_i = 32'h0; flush_i = 1'b0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0; dm_wstrb_i = 4'h0;
    ram_rdata_i = 32'h0;
    m_pend = 1'b0; m_owner = 1'b0; m_drop = 1'b0; m_due = 0; m_streak = 0; m_data = 32'h0;
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
      e_mem[i] = m_mem[i];
    end
    m_mem[0] = 32'h0280_0421;
    e_mem[0] = 32'h0280_0421;
    @(negedge clk_i);

    // reset state
    repeat (2) step();
    rst_ni = 1'b1;
    step();

    // fetch read
    if_req_i = 1'b1; if_addr_i = 32'h1C00_0000;
    step();
    check_eq("fetch_gnt_T", o_if_gnt, 1'b1);
    check_eq("fetch_en_T", o_ram_en, 1'b1);
    if_req_i = 1'b0; if_addr_i = 32'h0;
    for (int k = 1; k <= LAT; k++) begin
      step();
      check_eq("fetch_rvalid_only_at_lat", o_ifv, k == LAT);
    end
    check_eq("fetch_rdata", o_if_rdata, 32'h0280_0421);

    // conflict
    if_req_i = 1'b1; if_addr_i = 32'h1C00_0004;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_0008;
    step();
    check_eq("conflict_dm_first", o_dm_gnt, 1'b1);
    check_eq("conflict_if_held", o_if_gnt, 1'b0);
    dm_req_i = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      step();
      check_eq("conflict_if_gnt", o_if_gnt, k == LAT);
      check_eq("conflict_dm_rvalid", o_dmv, k == LAT);
    end
    if_req_i = 1'b0;
    repeat (LAT) step();

    // starvation: stores and fetches held continuously
    if_req_i = 1'b1; if_addr_i = 32'h0000_0004;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_wstrb_i = 4'hF; dm_addr_i = 32'h9; dm_wdata_i = 32'hCAFE_0000;
    for (int k = 0; k < 2 * (MAX + LAT); k++) begin
      int ph;
      ph = k % (MAX + LAT);
      step();
      check_eq("starve_dm_gnt", o_dm_gnt, ph < MAX);
      check_eq("starve_if_gnt", o_if_gnt, ph == MAX);
      dm_wdata_i = $urandom;
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
    repeat (LAT) step();

    // store burst
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_wstrb_i = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      dm_addr_i = 32'(k + 1); dm_wdata_i = $urandom;
      step();
      check_eq("burst_gnt", o_dm_gnt, 1'b1);
      check_eq("burst_we", o_ram_we, 4'b0011);
      check_eq("burst_no_rvalid", o_dmv, 1'b0);
    end
    dm_req_i = 1'b0;
    step();
    check_eq("burst_no_rvalid_after", o_dmv, 1'b0);

    // flush during fetch
    if_req_i = 1'b1; if_addr_i = 32'h2;
    step();
    check_eq("flush_fetch_gnt", o_if_gnt, 1'b1);
    if_req_i = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    step();
    if_req_i = 1'b1; if_addr_i = 32'h3;
    step();
    check_eq("flush_no_rvalid", o_ifv, 1'b0);
    check_eq("flush_regrant", o_if_gnt, 1'b1);
    if_req_i = 1'b0;
    repeat (LAT) step();

    // reset in the middle of a DM load
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h5;
    step();
    check_eq("rst_load_gnt", o_dm_gnt, 1'b1);
    dm_req_i = 1'b0;
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    check_eq("rst_T2_en", o_ram_en, 1'b0);
    step();
    check_eq("rst_T3_no_dm_rvalid", o_dmv, 1'b0);
    if_req_i = 1'b1; if_addr_i = 32'h7;
    step();
    check_eq("post_rst_gnt", o_if_gnt, 1'b1);
    if_req_i = 1'b0;
    repeat (LAT) step();

    // randomized traffic with requests held until granted
    for (int n = 0; n < 3000; n++) begin
      if (!if_req_i && $urandom_range(0, 3) != 0) begin
        if_req_i = 1'b1; if_addr_i = $urandom;
      end
      if (!dm_req_i && $urandom_range(0, 2) != 0) begin
        dm_req_i = 1'b1; dm_we_i = 1'($urandom); dm_addr_i = $urandom;
        dm_wdata_i = $urandom; dm_wstrb_i = 4'($urandom);
      end
      flush_i = ($urandom_range(0, 7) == 0);
      rst_ni  = ($urandom_range(0, 249) != 0);
      step();
      if (g_if) if_req_i = 1'b0;
      if (g_dm) dm_req_i = 1'b0;
    end
    rst_ni = 1'b1; if_req_i = 1'b0; dm_req_i = 1'b0; flush_i = 1'b0;
    repeat (LAT + 1) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
